// File: rtl/usbdev_line_monitor.sv
// USB device line-state monitor: glitch-filters the raw D+/D- levels, times SE0 and
// J idle against the 1 us strobe, and tracks the link state with single-cycle events.
module usbdev_line_monitor #(
  parameter int unsigned FilterCycles = 3,
  parameter int unsigned ResetUs      = 3,
  parameter int unsigned SuspendUs    = 3000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       usb_rx_dp_i,
  input  logic       usb_rx_dn_i,
  input  logic       usb_pwr_sense_i,
  input  logic       usb_dp_pullup_en_i,
  input  logic       tick_us_i,
  output logic [1:0] line_state_o,
  output logic [2:0] link_state_o,
  output logic       evt_powered_o,
  output logic       evt_reset_o,
  output logic       evt_suspend_o,
  output logic       evt_resume_o,
  output logic       evt_disconnect_o
);

  localparam int unsigned RunW = $clog2(FilterCycles + 1);

  typedef enum logic [1:0] {
    LS_SE0 = 2'd0,
    LS_J   = 2'd1,
    LS_K   = 2'd2,
    LS_SE1 = 2'd3
  } line_e;

  typedef enum logic [2:0] {
    LINK_DISCONNECTED = 3'd0,
    LINK_POWERED      = 3'd1,
    LINK_ACTIVE       = 3'd2,
    LINK_SUSPENDED    = 3'd3,
    LINK_RESUMING     = 3'd4
  } link_e;

  function automatic logic [RunW-1:0] run_sat_inc(input logic [RunW-1:0] r);
    if (r >= RunW'(FilterCycles)) return r;
    return r + RunW'(1);
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] c);
    if (c == 4'hF) return c;
    return c + 4'd1;
  endfunction

  function automatic logic [11:0] sat_inc12(input logic [11:0] c);
    if (c == 12'hFFF) return c;
    return c + 12'd1;
  endfunction

  // Stage p0: line filter and microsecond timers
  logic [1:0]      raw;
  logic [1:0]      raw_last_p0;
  logic [RunW-1:0] run_p0;
  logic [RunW-1:0] run_d;
  line_e           line_p0;
  logic [3:0]      se0_cnt_p0;
  logic [3:0]      se0_cnt_d;
  logic [11:0]     idle_cnt_p0;
  logic [11:0]     idle_cnt_d;
  logic            se0_active;
  logic            idle_active;
  logic            bus_reset;
  logic            suspend_hit;

  // J is dp=1,dn=0 -> code 1, K is dp=0,dn=1 -> code 2
  assign raw   = {usb_rx_dn_i, usb_rx_dp_i};
  assign run_d = (raw == raw_last_p0) ? run_sat_inc(run_p0) : RunW'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      raw_last_p0 <= 2'd0;
      run_p0      <= '0;
      line_p0     <= LS_SE0;
    end else begin
      raw_last_p0 <= raw;
      run_p0      <= run_d;
      if (run_d >= RunW'(FilterCycles)) line_p0 <= line_e'(raw);
    end
  end

  logic  connected;
  link_e link_p1;
  link_e link_d;
  logic  resume_seen_p1;
  logic  resume_seen_d;
  logic  evt_powered_d, evt_reset_d, evt_suspend_d, evt_resume_d, evt_disconnect_d;

  assign connected   = usb_pwr_sense_i & usb_dp_pullup_en_i;
  assign se0_active  = (line_p0 == LS_SE0);
  assign idle_active = (link_p1 == LINK_ACTIVE) && (line_p0 == LS_J);
  // Exact-match on the incrementing tick so each interval fires once, never again at saturation
  assign bus_reset   = se0_active && tick_us_i && (se0_cnt_p0 != 4'hF) &&
                       (sat_inc4(se0_cnt_p0) == 4'(ResetUs));
  assign suspend_hit = idle_active && tick_us_i && (idle_cnt_p0 != 12'hFFF) &&
                       (sat_inc12(idle_cnt_p0) == 12'(SuspendUs));

  always_comb begin
    se0_cnt_d = se0_cnt_p0;
    if (!se0_active)    se0_cnt_d = 4'd0;
    else if (tick_us_i) se0_cnt_d = sat_inc4(se0_cnt_p0);
    idle_cnt_d = idle_cnt_p0;
    if (!idle_active)   idle_cnt_d = 12'd0;
    else if (tick_us_i) idle_cnt_d = sat_inc12(idle_cnt_p0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      se0_cnt_p0  <= 4'd0;
      idle_cnt_p0 <= 12'd0;
    end else begin
      se0_cnt_p0  <= se0_cnt_d;
      idle_cnt_p0 <= idle_cnt_d;
    end
  end

  // Stage p1: link state machine and event pulses
  always_comb begin
    link_d           = link_p1;
    evt_powered_d    = 1'b0;
    evt_reset_d      = 1'b0;
    evt_suspend_d    = 1'b0;
    evt_resume_d     = 1'b0;
    evt_disconnect_d = 1'b0;
    resume_seen_d    = (link_p1 == LINK_RESUMING) ? (resume_seen_p1 | se0_active) : 1'b0;
    if (link_p1 != LINK_DISCONNECTED && !connected) begin
      link_d           = LINK_DISCONNECTED;
      evt_disconnect_d = 1'b1;
    end else begin
      case (link_p1)
        LINK_DISCONNECTED: begin
          if (connected) begin
            link_d        = LINK_POWERED;
            evt_powered_d = 1'b1;
          end
        end
        LINK_POWERED: begin
          if (bus_reset) begin
            link_d      = LINK_ACTIVE;
            evt_reset_d = 1'b1;
          end
        end
        LINK_ACTIVE: begin
          if (bus_reset) begin
            evt_reset_d = 1'b1;
          end else if (suspend_hit) begin
            link_d        = LINK_SUSPENDED;
            evt_suspend_d = 1'b1;
          end
        end
        LINK_SUSPENDED: begin
          if (bus_reset) begin
            link_d      = LINK_ACTIVE;
            evt_reset_d = 1'b1;
          end else if (line_p0 == LS_K) begin
            link_d = LINK_RESUMING;
          end
        end
        LINK_RESUMING: begin
          if (bus_reset) begin
            link_d      = LINK_ACTIVE;
            evt_reset_d = 1'b1;
          end else if (line_p0 == LS_J && resume_seen_p1) begin
            link_d       = LINK_ACTIVE;
            evt_resume_d = 1'b1;
          end
        end
        default: link_d = LINK_DISCONNECTED;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      link_p1          <= LINK_DISCONNECTED;
      resume_seen_p1   <= 1'b0;
      evt_powered_o    <= 1'b0;
      evt_reset_o      <= 1'b0;
      evt_suspend_o    <= 1'b0;
      evt_resume_o     <= 1'b0;
      evt_disconnect_o <= 1'b0;
    end else begin
      link_p1          <= link_d;
      resume_seen_p1   <= resume_seen_d;
      evt_powered_o    <= evt_powered_d;
      evt_reset_o      <= evt_reset_d;
      evt_suspend_o    <= evt_suspend_d;
      evt_resume_o     <= evt_resume_d;
      evt_disconnect_o <= evt_disconnect_d;
    end
  end

  assign line_state_o = line_p0;
  assign link_state_o = link_p1;

endmodule

// File: doc/usbdev_line_monitor.md
USBDEV_LINE_MONITOR -- requirements
Module: usbdev_line_monitor

Interface
REQ-001 The block SHALL provide these parameters (name, default, meaning): FilterCycles, 3, consecutive identical raw samples needed to accept a line state.
REQ-002 ResetUs, 3, filtered SE0 duration in microseconds that signals a bus reset; legal range 1..15.
REQ-003 SuspendUs, 3000, filtered J idle duration in microseconds that signals a suspend; legal range 1..4095.
REQ-004 The block SHALL provide these ports (name, direction, width, meaning): clk_i, in, 1, usb clock, the only clock.
REQ-005 rst_ni, in, 1, reset, synchronous, active-low.
REQ-006 usb_rx_dp_i / usb_rx_dn_i, in, 1 each, synchronized single-ended bus levels from the IO mux.
REQ-007 usb_pwr_sense_i, in, 1, synchronized VBUS sense from the IO mux.
REQ-008 usb_dp_pullup_en_i, in, 1, device connect request, the same value driven towards the IO mux.
REQ-009 tick_us_i, in, 1, single-cycle 1 us strobe.
REQ-010 line_state_o, out, 2, filtered line state: 0 SE0, 1 J (dp=1,dn=0), 2 K (dp=0,dn=1), 3 SE1.
REQ-011 link_state_o, out, 3, link state: 0 DISCONNECTED, 1 POWERED, 2 ACTIVE, 3 SUSPENDED, 4 RESUMING.
REQ-012 evt_powered_o, evt_reset_o, evt_suspend_o, evt_resume_o, evt_disconnect_o, out, 1 each, single-cycle event pulses.

Function
REQ-013 Filter: a raw {dp,dn} value SHALL load line_state_o on the edge on which it has been sampled unchanged for FilterCycles consecutive cycles; shorter glitches SHALL leave line_state_o unchanged.
REQ-014 SE0 timer: a 4-bit counter SHALL increment on tick_us_i while line_state_o is SE0, saturate at 15, and clear on the first cycle line_state_o is not SE0.
REQ-015 A bus reset condition SHALL occur only on the cycle the SE0 timer increments to exactly ResetUs, i.e. once per SE0 interval.
REQ-016 Idle timer: a 12-bit counter SHALL increment on tick_us_i while link_state_o is ACTIVE and line_state_o is J, saturate at 4095, and clear otherwise.
REQ-017 The suspend condition SHALL occur only on the cycle the idle timer increments to exactly SuspendUs.
REQ-018 connected is usb_pwr_sense_i AND usb_dp_pullup_en_i; in any state other than DISCONNECTED, connected low SHALL move to DISCONNECTED and pulse evt_disconnect_o, with priority over all other transitions.
REQ-019 DISCONNECTED: connected high SHALL move to POWERED and pulse evt_powered_o.
REQ-020 POWERED, SUSPENDED, RESUMING: a bus reset condition SHALL move to ACTIVE and pulse evt_reset_o.
REQ-021 ACTIVE: a bus reset condition SHALL pulse evt_reset_o and stay ACTIVE; otherwise the suspend condition SHALL move to SUSPENDED and pulse evt_suspend_o.
REQ-022 SUSPENDED: line_state_o K SHALL move to RESUMING.
REQ-023 RESUMING: a set-once flag SHALL record any filtered SE0 cycle; line_state_o J with the flag set SHALL move to ACTIVE and pulse evt_resume_o.
REQ-024 In RESUMING, a bus reset condition SHALL take priority over resume completion on the same cycle.
REQ-025 All outputs SHALL be registered; link_state_o and the matching event pulse SHALL update on the same edge, one cycle after the triggering condition is sampled.
REQ-026 At most one evt_* output SHALL be high in any cycle.

Reset
REQ-027 With rst_ni low at a clk_i rising edge: line_state_o=0 (SE0), link_state_o=0 (DISCONNECTED), all evt_* outputs=0, all counters, the filter history and the RESUMING flag=0.
REQ-028 Reset asserted mid-operation SHALL take effect at the next edge, and no event SHALL pulse on that edge.

Verification
REQ-029 Connect: pwr_sense=1, pullup=1 -> one evt_powered_o pulse, link_state_o=1.
REQ-030 Bus reset: in POWERED, SE0 held for 3 ticks -> one evt_reset_o, link_state_o=2; SE0 held 20 ticks -> still exactly one pulse.
REQ-031 Glitch: 2-cycle K pulse on an idle J line with FilterCycles=3 -> line_state_o stays 1, idle timer not cleared.
REQ-032 Suspend/resume: ACTIVE with J for 3000 ticks -> evt_suspend_o, state 3. Then K for 10 ticks -> state 4. Then SE0 for 2 ticks, then J -> evt_resume_o, state 2.
REQ-033 Priority: pwr_sense drops in the same cycle the suspend count is reached -> only evt_disconnect_o, state 0.
REQ-034 Reset mid-operation: rst_ni low while SUSPENDED -> all outputs at reset values next edge; no event pulse.
